player_input_conditioner: RTL and testbench
===========================================

# player_input_conditioner

Conditions the raw left/right player buttons into clean, mutually exclusive movement commands for the doodle motion logic. It synchronises and debounces both buttons, arbitrates simultaneous presses (last-pressed wins), and latches the resulting command on every physics tick. The command therefore stays constant for a whole physics period, and a short tap between ticks is never lost. It sits between the board-level button inputs and the doodle manager, and consumes the `physicsUpdate` toggle produced by the physics clock divider.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised button must disagree with its stable level before that level flips; legal range ≥ 1.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `left` in 1: raw left button, asynchronous to `clk`, may bounce.
- `right` in 1: raw right button, same properties as `left`.
- `physicsUpdate` in 1: physics toggle signal, synchronous to `clk`; each change of level (either direction) is one physics tick.
- `moveLeft` out 1: latched left command for the current physics period.
- `moveRight` out 1: latched right command for the current physics period.
- `tick` out 1: one-cycle pulse marking the cycle in which `moveLeft`/`moveRight` were updated.

## Operation
- **Synchroniser:** a 2-flop chain per button; `sL`/`sR` is the second flop.
- **Debounce:** each channel has a stable level and a counter of width clog2(`DEBOUNCE_CYCLES`+1).
  - When the synchronised value equals the stable level, the counter is 0.
  - Otherwise the counter increments each cycle. On the cycle it would reach `DEBOUNCE_CYCLES`, the stable level flips and the counter returns to 0.
  - Any agreement before that point clears the counter.
  - The counter never wraps.
- **Rise detect:** `riseX` = stable & ~stable_prev. It is a one-cycle pulse.
- **Arbiter FSM** with states IDLE, LEFT, RIGHT. Priority, evaluated each cycle:
  - `riseL` & ~`riseR` → LEFT.
  - `riseR` & ~`riseL` → RIGHT.
  - State LEFT and stable L low → RIGHT if stable R is high, else IDLE.
  - State RIGHT and stable R low → LEFT if stable L is high, else IDLE.
  - State IDLE and exactly one stable level high → that direction.
  - Both rise in the same cycle → stay IDLE (tie: no movement until one button is released).
  - Otherwise hold.
- **Pending register** (IDLE/LEFT/RIGHT): records the most recent non-IDLE state the FSM entered since the last tick. This captures taps shorter than a physics period.
- **Tick detect:** `phPrev` <= `physicsUpdate` every cycle; a tick occurs when `physicsUpdate` != `phPrev`.
- **On a tick cycle:**
  - The command is the current (pre-update) FSM state if it is non-IDLE; otherwise it is the pending value.
  - `moveLeft` <= (command == LEFT) and `moveRight` <= (command == RIGHT).
  - `tick` <= 1.
  - Pending is cleared, unless the FSM enters a non-IDLE state in that same cycle; then set wins.
- **Non-tick cycles:** `moveLeft`/`moveRight` hold and `tick` <= 0.
- **Invariant:** `moveLeft` & `moveRight` is never 1.

## Timing
- **Reset** (`reset`=0 at a clock edge):
  - Sync flops, stable levels, counters, `stable_prev` → 0.
  - FSM → IDLE and pending → IDLE.
  - `moveLeft`, `moveRight`, `tick` → 0.
  - `phPrev` <= `physicsUpdate`, so no spurious tick occurs on the first cycle after release.
  - Reset in mid-press discards all history; a button still held re-debounces from zero.
- **Latency, raw press to FSM state:** `DEBOUNCE_CYCLES`+3 edges (2 sync + debounce + 1 FSM).
- **Latency, FSM state to outputs:** at the next tick edge. `moveLeft`/`moveRight` and `tick` change on that same edge.
- **Latency, `physicsUpdate` change to `tick`:** `tick` is high in the cycle following the edge that samples the change.
- **Tick coincident with FSM transition:** outputs use the old state; the new state is reflected at the following tick.
- **Back-to-back ticks** (`physicsUpdate` toggling every cycle): each is honoured; `tick` stays high continuously.
- **No handshake:** the downstream block samples `moveLeft`/`moveRight` at any time, or qualifies the sample with `tick`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `physicsUpdate` toggling every 50 cycles unless stated.

1. **Reset:** `reset`=0 for 5 cycles with `left`=1 and `physicsUpdate` toggling → `moveLeft`=`moveRight`=`tick`=0 throughout. First cycle after release: `tick`=0.
2. **Clean hold:** `left` rises at cycle 0 and is held → FSM reaches LEFT at edge 7. At the first tick after that, `moveLeft`=1 with `tick`=1. `moveLeft` stays 1 at each tick until `left` has been released for ≥7 cycles before a tick, then `moveLeft`=0 at that tick.
3. **Bounce rejection:** `left` toggles every 2 cycles for 40 cycles, then stays 0 → stable L never rises and `moveLeft`=0 at every tick.
4. **Last-pressed wins:** hold `left`; after LEFT is latched, press `right` → next tick gives `moveRight`=1, `moveLeft`=0. Release `right` with `left` still held → next tick gives `moveLeft`=1.
5. **Simultaneous press:** `left` and `right` rise on the same cycle and are held → both outputs 0 at every tick. Release `right` → LEFT, and `moveLeft`=1 at the next tick.
6. **Short tap:** `physicsUpdate` period 200 cycles; `left`=1 for 10 cycles mid-period → exactly one tick latches `moveLeft`=1, and the following tick returns `moveLeft`=0.

Source files
------------

// File: rtl/player_input_conditioner.sv
// player_input_conditioner: turns raw left/right buttons into clean, mutually
// exclusive movement commands that are latched once per physics tick.
//
// Ports:
//   clk           in  system clock, rising-edge active
//   reset         in  synchronous active-low reset
//   left          in  raw left button (asynchronous, bouncy)
//   right         in  raw right button (asynchronous, bouncy)
//   physicsUpdate in  physics toggle; every level change is one tick
//   moveLeft      out left command for the current physics period
//   moveRight     out right command for the current physics period
//   tick          out one-cycle pulse on the cycle the commands were updated
module player_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic physicsUpdate,
    output logic moveLeft,
    output logic moveRight,
    output logic tick
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    // Channel index 0 is left, 1 is right.
    logic [1:0]    raw;
    logic [1:0]    s1_q, s2_q, stab_q, stab_d, prev_q, rise;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    state_t        state_q, state_d, pend_q, pend_d, cmd;
    logic          ph_prev_q, ph_tick, entered;

    assign raw  = {right, left};
    assign rise = stab_q & ~prev_q;

    // Stable level flips once the synchronised value has disagreed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stab_d[i] = stab_q[i];
            cnt_d[i]  = '0;
            if (s2_q[i] != stab_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))
                    stab_d[i] = ~stab_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Last-pressed wins; a simultaneous press parks in IDLE until one button
    // is released, after which the remaining held button takes over.
    always_comb begin
        state_d = state_q;
        if (rise[0] && !rise[1])
            state_d = LEFT;
        else if (rise[1] && !rise[0])
            state_d = RIGHT;
        else if (rise[0] && rise[1])
            state_d = IDLE;
        else if (state_q == LEFT && !stab_q[0])
            state_d = stab_q[1] ? RIGHT : IDLE;
        else if (state_q == RIGHT && !stab_q[1])
            state_d = stab_q[0] ? LEFT : IDLE;
        else if (state_q == IDLE && (stab_q[0] ^ stab_q[1]))
            state_d = stab_q[0] ? LEFT : RIGHT;
    end

    assign ph_tick = physicsUpdate ^ ph_prev_q;
    assign entered = (state_d != IDLE) && (state_d != state_q);
    // Pending remembers a tap that came and went between ticks.
    assign cmd     = (state_q != IDLE) ? state_q : pend_q;
    assign pend_d  = entered ? state_d : (ph_tick ? IDLE : pend_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stab_q    <= '0;
            prev_q    <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            state_q   <= IDLE;
            pend_q    <= IDLE;
            ph_prev_q <= physicsUpdate;
            moveLeft  <= 1'b0;
            moveRight <= 1'b0;
            tick      <= 1'b0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            stab_q    <= stab_d;
            prev_q    <= stab_q;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
            state_q   <= state_d;
            pend_q    <= pend_d;
            ph_prev_q <= physicsUpdate;
            moveLeft  <= ph_tick ? (cmd == LEFT) : moveLeft;
            moveRight <= ph_tick ? (cmd == RIGHT) : moveRight;
            tick      <= ph_tick;
        end
    end
endmodule

// File: tb/tb_player_input_conditioner.sv
// tb_player_input_conditioner: directed self-checking bench for
// player_input_conditioner with DEBOUNCE_CYCLES=4.
//
// Drives inputs and samples outputs on the falling edge; physics ticks are
// issued explicitly so each latched command lands on a known edge.
module tb_player_input_conditioner;
    logic clk = 1'b0;
    logic reset, left, right, physicsUpdate;
    logic moveLeft, moveRight, tick;
    int   checks = 0;
    int   errors = 0;

    player_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .left(left),
        .right(right),
        .physicsUpdate(physicsUpdate),
        .moveLeft(moveLeft),
        .moveRight(moveRight),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed {tick,ml,mr}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Toggle the physics signal; one edge later the outputs must show the
    // latched command with tick high.
    task automatic tick_chk(input string tag, input logic ml, input logic mr);
        physicsUpdate = ~physicsUpdate;
        @(negedge clk);
        chk(tag, {tick, moveLeft, moveRight}, {1'b1, ml, mr});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        left = 1'b1;
        right = 1'b0;
        physicsUpdate = 1'b0;
        // Reset held with left pressed and physics toggling every cycle.
        for (int i = 0; i < 5; i++) begin
            physicsUpdate = ~physicsUpdate;
            @(negedge clk);
            chk("reset_hold", {tick, moveLeft, moveRight}, 3'b000);
        end
        reset = 1'b1;
        left = 1'b0;
        @(negedge clk);
        chk("post_reset_no_tick", {tick, moveLeft, moveRight}, 3'b000);
        idle(10);

        // Clean hold: LEFT appears exactly at edge 7, so a tick at edge 7
        // still sees IDLE and a back-to-back tick at edge 8 sees LEFT.
        left = 1'b1;
        idle(6);
        tick_chk("hold_tick_at_edge7", 1'b0, 1'b0);
        tick_chk("hold_tick_at_edge8", 1'b1, 1'b0);
        idle(20);
        tick_chk("hold_still", 1'b1, 1'b0);
        left = 1'b0;
        idle(6);
        tick_chk("release_edge7_still_left", 1'b1, 1'b0);
        tick_chk("release_edge8_idle", 1'b0, 1'b0);
        @(negedge clk);
        chk("tick_drops", {tick, moveLeft, moveRight}, 3'b000);
        idle(10);

        // Bounce rejection: 2-cycle pulses never satisfy a 4-cycle debounce.
        for (int i = 0; i < 20; i++) begin
            left = ~left;
            idle(2);
        end
        left = 1'b0;
        idle(10);
        tick_chk("bounce_1", 1'b0, 1'b0);
        idle(20);
        tick_chk("bounce_2", 1'b0, 1'b0);

        // Last-pressed wins.
        left = 1'b1;
        idle(10);
        tick_chk("lpw_left", 1'b1, 1'b0);
        right = 1'b1;
        idle(7);
        tick_chk("lpw_right_over_left", 1'b0, 1'b1);
        right = 1'b0;
        idle(7);
        tick_chk("lpw_back_to_left", 1'b1, 1'b0);
        left = 1'b0;
        idle(10);
        tick_chk("lpw_all_released", 1'b0, 1'b0);

        // Simultaneous press parks in IDLE until right is released.
        left = 1'b1;
        right = 1'b1;
        idle(10);
        tick_chk("tie_1", 1'b0, 1'b0);
        idle(20);
        tick_chk("tie_2", 1'b0, 1'b0);
        right = 1'b0;
        idle(7);
        tick_chk("tie_release_right", 1'b1, 1'b0);
        left = 1'b0;
        idle(10);
        tick_chk("tie_all_released", 1'b0, 1'b0);

        // Short taps between ticks are latched once, then cleared.
        left = 1'b1;
        idle(10);
        left = 1'b0;
        idle(20);
        tick_chk("tap_left_latched", 1'b1, 1'b0);
        idle(30);
        tick_chk("tap_left_cleared", 1'b0, 1'b0);
        right = 1'b1;
        idle(10);
        right = 1'b0;
        idle(20);
        tick_chk("tap_right_latched", 1'b0, 1'b1);
        idle(30);
        tick_chk("tap_right_cleared", 1'b0, 1'b0);

        // Reset mid-press clears outputs and forces a full re-debounce.
        left = 1'b1;
        idle(10);
        tick_chk("pre_reset_left", 1'b1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_clears_outputs", {tick, moveLeft, moveRight}, 3'b000);
        reset = 1'b1;
        idle(6);
        tick_chk("redebounce_edge7", 1'b0, 1'b0);
        tick_chk("redebounce_edge8", 1'b1, 1'b0);
        left = 1'b0;
        idle(10);
        tick_chk("final_idle", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
